// File: rtl/fp32_pkg.sv
// fp32_pkg: shared IEEE-754 single-precision definitions.
// Provides the field widths, the signed-zero and infinity encodings, the
// unpacked-operand struct, and the unpack and alignment helpers. The
// pipelined subtractor uses this package, and the adder is meant to use it too.
package fp32_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] FP32_PZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_PINF  = 32'h7F80_0000;
  localparam logic [31:0] FP32_NINF  = 32'hFF80_0000;

  // Any biased exponent at or above this value saturates to infinity.
  localparam logic signed [9:0] EXP_SAT = 10'(2 * BIAS + 1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant24;
  } fp32_unp_t;

  // Exponent 0 reads as zero, so denormals are flushed and the hidden bit is dropped.
  function automatic fp32_unp_t fp32_unpack(input logic [31:0] v);
    fp32_unp_t u;
    u.sign   = v[31];
    u.exp    = v[30:23];
    u.mant24 = (v[30:23] == 8'd0) ? 24'd0 : {1'b1, v[22:0]};
    return u;
  endfunction

  // Bits shifted out are dropped. A shift of 24 or more leaves nothing.
  function automatic logic [23:0] fp32_align(input logic [23:0] mant,
                                             input logic [7:0]  diff);
    return (diff >= 8'd24) ? 24'd0 : (mant >> diff);
  endfunction

endpackage

// File: rtl/fp32_lzc.sv
// fp32_lzc: 24-bit leading-zero counter.
// Ports:
//   i_val [23:0] : value to scan
//   o_cnt [4:0]  : number of leading zeros; 24 when i_val is all zeros
module fp32_lzc (
  input  logic [23:0] i_val,
  output logic [4:0]  o_cnt
);

  // Scan from LSB upward so the highest set bit writes the count last.
  always_comb begin
    o_cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (i_val[i]) begin
        o_cnt = 5'(23 - i);
      end else begin
        o_cnt = o_cnt;
      end
    end
  end

endmodule

// File: rtl/float_subtractor.sv
// float_subtractor: pipelined IEEE-754 single-precision x - y, truncating.
// The design has four register ranks: align, add/sub, normalize, and output.
// A result appears 3 cycles after the accept edge.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   x, y                : minuend and subtrahend
//   valid_inx/valid_iny : operand valids; a pair is accepted only when both are high
//   in_ready            : pipeline can take a pair this cycle
//   data_out, valid_out : registered result and its valid bit
//   out_ready           : consumer takes data_out this cycle
module float_subtractor
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        valid_inx,
  input  logic        valid_iny,
  output logic        in_ready,
  output logic [31:0] data_out,
  output logic        valid_out,
  input  logic        out_ready
);

  logic        w_advance, w_accept;
  fp32_unp_t   w_ux, w_uy;
  logic [7:0]  w_ebig;
  logic [23:0] w_ma, w_mb;
  logic [24:0] w_m;
  logic        w_sign;
  logic [4:0]  w_lz;
  logic signed [9:0] w_exp;
  logic [22:0] w_mant;
  logic [31:0] w_res;

  logic        r_s1_valid, r_s1_sx, r_s1_sy;
  logic [7:0]  r_s1_ebig;
  logic [23:0] r_s1_ma, r_s1_mb;
  logic        r_s2_valid, r_s2_sign;
  logic [7:0]  r_s2_ebig;
  logic [24:0] r_s2_m;
  logic        r_s3_valid;
  logic [31:0] r_s3_res;
  logic        r_valid_out;
  logic [31:0] r_data_out;

  // The whole pipeline moves together. It stalls only when the output holds a result nobody takes.
  assign w_advance = !r_valid_out || out_ready;
  assign w_accept  = valid_inx && valid_iny && w_advance;
  assign in_ready  = w_advance;
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;

  // Align: subtraction is addition with y's sign inverted; shift the smaller mantissa.
  always_comb begin
    w_ux      = fp32_unpack(x);
    w_uy      = fp32_unpack(y);
    w_uy.sign = ~y[31];
    if (w_ux.exp >= w_uy.exp) begin
      w_ebig = w_ux.exp;
      w_ma   = w_ux.mant24;
      w_mb   = fp32_align(w_uy.mant24, w_ux.exp - w_uy.exp);
    end else begin
      w_ebig = w_uy.exp;
      w_ma   = fp32_align(w_ux.mant24, w_uy.exp - w_ux.exp);
      w_mb   = w_uy.mant24;
    end
  end

  // Add/sub: the mantissas are already aligned, so comparing them directly compares magnitudes.
  always_comb begin
    if (r_s1_sx == r_s1_sy) begin
      w_m    = {1'b0, r_s1_ma} + {1'b0, r_s1_mb};
      w_sign = r_s1_sx;
    end else if (r_s1_ma > r_s1_mb) begin
      w_m    = {1'b0, r_s1_ma - r_s1_mb};
      w_sign = r_s1_sx;
    end else if (r_s1_mb > r_s1_ma) begin
      w_m    = {1'b0, r_s1_mb - r_s1_ma};
      w_sign = r_s1_sy;
    end else begin
      w_m    = 25'd0;
      w_sign = 1'b0;
    end
  end

  fp32_lzc u_lzc (
    .i_val (r_s2_m[23:0]),
    .o_cnt (w_lz)
  );

  // Normalize: compute the exponent in 10-bit signed so underflow and overflow stay visible.
  always_comb begin
    if (r_s2_m[24]) begin
      w_exp  = $signed({2'b00, r_s2_ebig}) + 10'sd1;
      w_mant = r_s2_m[23:1];
    end else begin
      w_exp  = $signed({2'b00, r_s2_ebig}) - $signed({5'b00000, w_lz});
      // The leading one shifts out past bit 22, so only the fraction remains.
      w_mant = 23'(r_s2_m[22:0] << w_lz);
    end
    if (r_s2_m == 25'd0) begin
      w_res = FP32_PZERO;
    end else if (w_exp <= 10'sd0) begin
      w_res = {r_s2_sign, 31'd0};
    end else if (w_exp >= EXP_SAT) begin
      w_res = r_s2_sign ? FP32_NINF : FP32_PINF;
    end else begin
      w_res = {r_s2_sign, w_exp[7:0], w_mant};
    end
  end

  // Pipeline registers: clear on reset; every rank holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sx     <= 1'b0;
      r_s1_sy     <= 1'b0;
      r_s1_ebig   <= 8'd0;
      r_s1_ma     <= 24'd0;
      r_s1_mb     <= 24'd0;
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_ebig   <= 8'd0;
      r_s2_m      <= 25'd0;
      r_s3_valid  <= 1'b0;
      r_s3_res    <= 32'd0;
      r_valid_out <= 1'b0;
      r_data_out  <= 32'd0;
    end else if (w_advance) begin
      r_s1_valid  <= w_accept;
      r_s1_sx     <= w_ux.sign;
      r_s1_sy     <= w_uy.sign;
      r_s1_ebig   <= w_ebig;
      r_s1_ma     <= w_ma;
      r_s1_mb     <= w_mb;
      r_s2_valid  <= r_s1_valid;
      r_s2_sign   <= w_sign;
      r_s2_ebig   <= r_s1_ebig;
      r_s2_m      <= w_m;
      r_s3_valid  <= r_s2_valid;
      r_s3_res    <= w_res;
      r_valid_out <= r_s3_valid;
      // A bubble leaves the last result visible rather than exposing stage garbage.
      if (r_s3_valid) begin
        r_data_out <= r_s3_res;
      end else begin
        r_data_out <= r_data_out;
      end
    end
  end

endmodule

// File: tb/tb_float_subtractor.sv
module tb_float_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] x = 32'd0;
  logic [31:0] y = 32'd0;
  logic        valid_inx = 1'b0;
  logic        valid_iny = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic [31:0] data_out;
  logic        valid_out;

  int total = 0;
  int bad   = 0;

  float_subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .valid_inx (valid_inx),
    .valid_iny (valid_iny),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_inx = 1'b0; valid_iny = 1'b0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++;
    if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 00000000", data_out); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  // One pair with an idle, ready consumer. Checks the 3-cycle latency and the result.
  task automatic run_one(input logic [31:0] ax, input logic [31:0] ay,
                         input logic [31:0] want, input string name);
    int cyc;
    x = ax; y = ay; valid_inx = 1'b1; valid_iny = 1'b1; out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
    tick;
    valid_inx = 1'b0; valid_iny = 1'b0;
    cyc = 0;
    while (valid_out !== 1'b1 && cyc < 10) begin
      tick;
      cyc++;
    end
    total++;
    if (cyc != 3) begin bad++; $display("FAIL %s_latency: got %0d cycles want 3", name, cyc); end
    total++;
    if (data_out !== want) begin bad++; $display("FAIL %s_data: got %h want %h", name, data_out, want); end
    tick;
  endtask

  task automatic test_arith;
    run_one(32'h40400000, 32'h3F800000, 32'h40000000, "three_minus_one");
    run_one(32'h3F800000, 32'h40400000, 32'hC0000000, "one_minus_three");
    run_one(32'h3FC00000, 32'h3FC00000, 32'h00000000, "equal_cancel");
    run_one(32'h3F800000, 32'hBF800000, 32'h40000000, "one_minus_negone");
    run_one(32'h3F800000, 32'h3F400000, 32'h3E800000, "renorm_left");
    run_one(32'h4B800000, 32'h3F800000, 32'h4B800000, "shift24");
    run_one(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, "overflow_inf");
    run_one(32'h00800000, 32'h00400000, 32'h00800000, "denorm_flush");
    run_one(32'h80C00000, 32'h80800000, 32'h80000000, "underflow_negzero");
  endtask

  task automatic test_back_to_back_stall;
    logic [31:0] vx [5];
    logic [31:0] vy [5];
    logic [31:0] ve [5];
    int idx, acc;
    logic will_acc;
    vx[0] = 32'h40400000; vy[0] = 32'h3F800000; ve[0] = 32'h40000000;
    vx[1] = 32'h3F800000; vy[1] = 32'h40400000; ve[1] = 32'hC0000000;
    vx[2] = 32'h40A00000; vy[2] = 32'h3F800000; ve[2] = 32'h40800000;
    vx[3] = 32'h3FC00000; vy[3] = 32'h3FC00000; ve[3] = 32'h00000000;
    vx[4] = 32'h40000000; vy[4] = 32'h3F800000; ve[4] = 32'h3F800000;
    out_ready = 1'b0; idx = 0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 5) begin
        x = vx[idx]; y = vy[idx]; valid_inx = 1'b1; valid_iny = 1'b1;
      end
      will_acc = (in_ready === 1'b1) && (idx < 5);
      tick;
      if (will_acc) begin idx++; acc++; end
      if (valid_out === 1'b1) begin
        total++;
        if (data_out !== ve[0]) begin bad++; $display("FAIL stall_hold: got %h want %h", data_out, ve[0]); end
      end
    end
    total++;
    if (acc != 4) begin bad++; $display("FAIL stall_accepted: got %0d want 4", acc); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    valid_inx = 1'b0; valid_iny = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (valid_out !== 1'b1 || data_out !== ve[i]) begin
        bad++;
        $display("FAIL drain_%0d: got valid=%b data=%h want valid=1 data=%h", i, valid_out, data_out, ve[i]);
      end
      tick;
    end
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", valid_out); end
  endtask

  task automatic test_half_valid;
    out_ready = 1'b1;
    x = 32'h40400000; y = 32'h3F800000;
    valid_inx = 1'b1; valid_iny = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) valid_inx = 1'b0;
      tick;
      total++;
      if (valid_out !== 1'b0) begin bad++; $display("FAIL half_valid_%0d: got %b want 0", i, valid_out); end
    end
  endtask

  task automatic test_reset_flush;
    out_ready = 1'b1;
    x = 32'h40A00000; y = 32'h3F800000; valid_inx = 1'b1; valid_iny = 1'b1;
    tick;
    x = 32'h3F800000; y = 32'hBF800000;
    tick;
    valid_inx = 1'b0; valid_iny = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", valid_out); end
    total++;
    if (data_out !== 32'h0) begin bad++; $display("FAIL flush_data: got %h want 00000000", data_out); end
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if (valid_out !== 1'b0) begin bad++; $display("FAIL flush_stale_%0d: got %b want 0", i, valid_out); end
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_back_to_back_stall;
    test_half_valid;
    // Give the reset-flush check a nonzero data_out to clear first.
    run_one(32'h40400000, 32'h3F800000, 32'h40000000, "pre_flush");
    test_reset_flush;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
